// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e    : controller state encoding (2'd3 is unused and decodes to IDLE)
//   cnt_width  : bit-counter width for a given operand width, never below 1
package serial_add_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/adder.sv
// 1-bit full adder cell, the only arithmetic element of the serial adder.
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
module adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell is reused for WIDTH cycles,
// LSB first, with the carry held in a register between cycles.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, accepted only in IDLE
//   a, b, cin       : operands and carry-in, captured on the accepted start
//   busy            : high while bits are being added
//   done            : one-cycle pulse, sum/cout valid
//   sum, cout       : registered result, held until the next completion
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands captured when start is seen
// RUN     | one operand bit pair added per cycle, busy=1
// DONE    | result just loaded, done=1 for one cycle, then back to IDLE
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = cnt_width(WIDTH);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] opa_q;
   logic [WIDTH-1:0] opb_q;
   logic [WIDTH-1:0] part_q;
   logic [WIDTH-1:0] part_d;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic             fa_sum;
   logic             fa_cout;
   logic             last_bit;

   adder u_fa (
      .a    (opa_q[0]),
      .b    (opb_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Each new sum bit enters at the MSB, so after WIDTH shifts bit i holds
   // the sum produced in cycle i.
   always_comb begin
      part_d = part_q >> 1;
      part_d[WIDTH-1] = fa_sum;
   end

   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               opa_q   <= opa_q >> 1;
               opb_q   <= opb_q >> 1;
               part_q  <= part_d;
               carry_q <= fa_cout;
               if (last_bit) begin
                  // counter is left at WIDTH-1 rather than wrapping
                  sum_q   <= part_d;
                  cout_q  <= fa_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               // IDLE, and the unused encoding which behaves as IDLE
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
               if (start) begin
                  opa_q   <= a;
                  opb_q   <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH 8, 1 and 16.
module tb_serial_add_ctrl;

   logic clk;
   logic rst_n;

   logic        start8, cin8, busy8, done8, cout8;
   logic [7:0]  a8, b8, sum8;
   logic        start1, cin1, busy1, done1, cout1;
   logic [0:0]  a1, b1, sum1;
   logic        start16, cin16, busy16, done16, cout16;
   logic [15:0] a16, b16, sum16;

   int n_vec = 0;
   int n_err = 0;
   int dones16 = 0;
   int starts16 = 0;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

   serial_add_ctrl #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

   serial_add_ctrl #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .cout(cout16));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (done16) dones16++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the 8-bit DUT idle. poke re-pulses start in RUN
   // and DONE and scribbles over the operand inputs mid-operation.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input bit poke,
                      input string tag);
      logic [7:0] ps;
      logic       pc;
      int k, holds, busyc;
      ps = sum8; pc = cout8;
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      k = 0; holds = 0; busyc = 0;
      while (!done8 && k < 20) begin
         if (busy8) busyc++;
         if (sum8 !== ps || cout8 !== pc) holds++;
         if (poke && k == 3) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         end
         if (poke && k == 4) start8 = 1'b0;
         @(negedge clk);
         k++;
      end
      chk({tag, "_latency"}, k, 8);
      chk({tag, "_busy_cycles"}, busyc, 8);
      chk({tag, "_hold"}, holds, 0);
      chk({tag, "_busy_in_done"}, busy8, 0);
      chk({tag, "_sum"}, sum8, es);
      chk({tag, "_cout"}, cout8, ec);
      if (poke) start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk({tag, "_done_pulse"}, done8, 0);
      if (poke) begin
         @(negedge clk);
         chk({tag, "_no_requeue_busy"}, busy8, 0);
         chk({tag, "_no_requeue_done"}, done8, 0);
      end
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
      logic [16:0] exp;
      int k;
      exp = {1'b0, a} + {1'b0, b} + {16'd0, c};
      a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
      starts16++;
      @(negedge clk);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      k = 0;
      while (!done16 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("w16_latency", k, 16);
      chk("w16_result", {cout16, sum16}, exp);
      @(negedge clk);
   endtask

   // {cout,sum} for index {a,b,cin}
   logic [1:0] fa_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   initial begin
      int k, d;
      logic [2:0] abc;
      rst_n = 1'b0;
      start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_sum", sum8, 0);
      chk("rst_cout", cout8, 0);
      chk("rst_w16", {busy16, done16, cout16, sum16}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, "zero");
      op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, "ff_plus_1");
      // started in the first IDLE cycle after done
      op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0, "b2b");
      op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1, "poke");

      // asynchronous reset in the 4th RUN cycle
      a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_pre_busy", busy8, 1);
      chk("midrst_pre_sum", sum8, 8'h4B);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_sum", sum8, 0);
      chk("midrst_cout", cout8, 0);
      chk("midrst_busy", busy8, 0);
      chk("midrst_done", done8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      d = 0;
      repeat (12) begin
         @(negedge clk);
         if (done8 || busy8) d++;
      end
      chk("midrst_no_done", d, 0);
      op8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0, "after_rst");

      // WIDTH=1 truth table
      for (int i = 0; i < 8; i++) begin
         abc = 3'(i);
         a1 = abc[2]; b1 = abc[1]; cin1 = abc[0]; start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         chk("w1_busy", busy1, 1);
         k = 0;
         while (!done1 && k < 10) begin
            @(negedge clk);
            k++;
         end
         chk("w1_latency", k, 1);
         chk("w1_result", {cout1, sum1}, fa_tab[i]);
         @(negedge clk);
      end

      // WIDTH=16 random operations with idle gaps
      for (int i = 0; i < 200; i++) begin
         op16(16'($urandom), 16'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      op16(16'hFFFF, 16'hFFFF, 1'b1);
      repeat (3) @(negedge clk);
      chk("w16_done_count", dones16, starts16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial multi-bit adder controller. It time-shares one instance of the existing 1-bit full adder cell `adder` (ports a, b, cin, sum, cout) across WIDTH cycles, feeding one operand bit pair per cycle, LSB first.
- Sequencing is done by an FSM, a bit counter and a registered carry.
- Start/busy/done handshake to the requester.
- Smallest-area add path in the design, for cases where latency is acceptable.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; holds its value between completions.
- cout  output  1  registered carry-out; holds its value between completions.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state is updated on the rising edge of clk.
- Reset values (asserted at any time, including mid-RUN):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Counter, operand shift registers and carry register all cleared.
  - An in-flight operation is discarded; no done is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 -> capture a, b into shift registers and cin into the carry register; clear the counter; next state RUN.
  - start=0 -> stay in IDLE.
- RUN (busy=1):
  - Each edge, the full-adder cell sees bit[0] of each operand shift register plus the carry register.
  - Its sum bit shifts into the MSB of the partial-result register.
  - Its cout loads the carry register.
  - The operand registers shift right by 1 and the counter increments.
  - At the edge where counter == WIDTH-1 (edge E0+WIDTH):
    - Load the sum output from the final partial result, so bit i equals the adder output of cycle i.
    - Load the cout output from the final adder cout.
    - Next state DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state IDLE unconditionally.
- start in RUN or DONE is ignored: not queued, no effect on operands.
- The earliest accepted back-to-back start is the first IDLE cycle after DONE.
- Latency:
  - done is high in the cycle following edge E0+WIDTH.
  - That is WIDTH+1 cycles from the cycle in which start was sampled.
  - Throughput is one add per WIDTH+2 cycles.
- Output stability: sum/cout change only at the completion edge or on reset. They never show partial values during RUN.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Carry propagates only through the carry register, never combinationally across bits.
- Counter width: $clog2(WIDTH) bits, minimum 1. It never wraps inside an operation.
- WIDTH=1: RUN lasts exactly one cycle.
- Changes on a/b/cin after the capture edge have no effect on the operation in progress.

Decomposition:
- Shared package `serial_add_pkg`:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 decodes to IDLE.
  - Function computing counter width from WIDTH.
- Sub-module: instantiate the existing `adder` full-adder cell unchanged as the single arithmetic datapath element.
- FSM, counter, shift registers and output registers stay in serial_add_ctrl.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0, start pulse -> busy high 8 cycles, done one cycle at start+9, sum=8'h00, cout=0.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 started in the first IDLE cycle after done -> sum=8'h00, cout=1, and the prior result holds until that completion.
- WIDTH=8, a=8'h3C, b=8'h0F, cin=0; start re-pulsed during RUN and again during DONE, and a/b changed to 8'hFF mid-RUN -> exactly one done, sum=8'h4B, cout=0.
- WIDTH=8, start a=8'h80, b=8'h80; assert rst_n=0 asynchronously (between clock edges) at cycle 4 of RUN -> outputs 0 immediately, state IDLE, no done. After release, start a=8'h12, b=8'h34, cin=1 -> sum=8'h47, cout=0.
- WIDTH=1, all 8 combinations of a, b, cin -> each gives done 2 cycles after start, with {cout,sum} matching the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1; 0,1,1 -> sum=0, cout=1).
- WIDTH=16, randomized 200 operations with random idle gaps, checked against a + b + cin -> zero mismatches, and done count equals accepted start count.
